rara_tx: RTL and testbench
==========================

Name: rara_tx

Overview:
- Pattern transmitter for the RARA detector path. It emits 7-bit ASCII characters forming N back-to-back "RARA" frames on a valid/ready character stream.
- Sits upstream of the RARA detector in loopback and regression setups. It is also used as a protocol stimulus source.
- Frame count is latched at start. Completion is signalled by a one-cycle done pulse.

Parameters:
- CNT_W, 4, width of frame-count input and internal remaining-frame counter
- IDLE_CHAR, 7'h20, character driven on dout when not in an active character slot; also the separator character

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request to begin transmission; sampled only in IDLE
- count  in  CNT_W  number of RARA frames to send; latched on accepted start
- dout  out  7  ASCII character
- dout_valid  out  1  dout holds a character to be consumed
- dout_ready  in  1  downstream accepts dout this cycle
- busy  out  1  transmission in progress
- done  out  1  one-cycle pulse after the final character is accepted

Behaviour:
- Reset values (asynchronous, immediate, including mid-frame):
  - state=IDLE, dout=IDLE_CHAR, dout_valid=0, busy=0, done=0, remaining counter=0.
  - An interrupted frame is abandoned. No done pulse is produced.
- Character transfer: a character is transferred on a rising edge where dout_valid=1 and dout_ready=1.
- Stall: while dout_valid=1 and dout_ready=0, dout and state hold unchanged.
- All outputs are registered.
- States: IDLE, TR1, TA1, TR2, TA2, GAP. The character driven in each state:
  - TR1 and TR2 drive R (7'h52).
  - TA1 and TA2 drive A (7'h41).
  - GAP drives IDLE_CHAR with dout_valid=1.
- IDLE:
  - start=1 and count!=0: latch rem=count, set busy=1, go to TR1. The first 'R' is valid in the cycle after start is sampled (latency 1).
  - start=1 and count==0: ignored. No busy, no done.
- Frame progression: TR1 -> TA1 -> TR2 -> TA2, each step on transfer.
- TA2 transfer with rem==1:
  - Go to IDLE and set dout_valid=0, busy=0, dout=IDLE_CHAR.
  - done=1 for exactly the next cycle.
- TA2 transfer with rem>1: decrement rem, then go to GAP (macro absent) or TR2 (macro present). After GAP is transferred, go to TR1.
- start while busy: ignored; count is not re-sampled.
- start asserted in the done cycle: accepted normally, since the state is already IDLE.
- The counter never wraps. The maximum count, 2^CNT_W-1, sends that many frames.
- dout_ready is ignored when dout_valid=0.

Optional Feature:
- Macro: RARA_TX_OVERLAP_EN.
- Defined:
  - Successive frames share the trailing "RA". After TA2 with rem>1, go to TR2 (no GAP).
  - The stream is R A (R A)×N, i.e. 2N+2 characters.
  - An overlap-mode detector asserts eurika N times.
- Undefined:
  - Frames are separated by one GAP character: RARA␠RARA…
  - The stream is 5N-1 characters.
  - A non-overlap detector asserts eurika N times.

Decomposition:
- Shared package/include (the existing parameter include) holds:
  - ASCII constants R=7'h52 and A=7'h41, common to the detector and this block.
  - State encoding constants TX_IDLE..TX_GAP (3 bits).
- Sub-module rara_tx_cnt: CNT_W-bit loadable down-counter.
  - Inputs: load, dec.
  - Outputs: last (rem==1), zero.
  - Instantiated once.

Test Plan:
- Reset, then start=1 count=1 with dout_ready tied 1.
  - dout sequence R,A,R,A on 4 consecutive cycles starting 1 cycle after start.
  - done pulses 1 cycle after the last A; busy falls on the same edge.
- count=3 with dout_ready=1.
  - Macro absent: R A R A ␠ R A R A ␠ R A R A (14 chars), then done.
  - Macro present: R A R A R A R A (8 chars), then done.
  - Looped into the rara detector in matching mode, eurika counts 3.
- count=2 with dout_ready toggling 1,0,0,1,…
  - Stalled characters hold dout and dout_valid unchanged.
  - The sequence is identical to the unstalled run; no character is dropped or duplicated.
- start=1 count=0 -> no busy, no dout_valid, no done.
- start re-pulsed with count=5 during a count=2 run -> ignored; exactly 2 frames are sent.
- rst asserted asynchronously mid-frame (during TA1).
  - Outputs return to reset values immediately; no done pulse.
  - After rst deasserts, start count=1 produces a clean RARA.

Source files
------------

// File: rtl/rara_tx_pkg.sv
// Shared constants for the RARA pattern path: ASCII characters and transmitter state encoding.
package rara_tx_pkg;

  localparam int unsigned CHAR_W  = 7;
  localparam int unsigned STATE_W = 3;

  localparam logic [CHAR_W-1:0] ASCII_R = 7'h52;
  localparam logic [CHAR_W-1:0] ASCII_A = 7'h41;

  typedef enum logic [STATE_W-1:0] {
    TX_IDLE = 3'd0,
    TX_TR1  = 3'd1,
    TX_TA1  = 3'd2,
    TX_TR2  = 3'd3,
    TX_TA2  = 3'd4,
    TX_GAP  = 3'd5
  } tx_state_e;

endpackage

// File: rtl/rara_tx_cnt.sv
// Loadable down-counter tracking frames still to send; last/zero flags are registered.
module rara_tx_cnt #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             last,
  output logic             zero
);

  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] rem_nxt_c;

  // Decrement saturates at zero so the counter never wraps.
  always_comb begin
    rem_nxt_c = rem;
    if (load)
      rem_nxt_c = load_val;
    else if (dec && (rem != '0))
      rem_nxt_c = rem - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem  <= '0;
      last <= 1'b0;
      zero <= 1'b1;
    end else begin
      rem  <= rem_nxt_c;
      last <= (rem_nxt_c == CNT_W'(1));
      zero <= (rem_nxt_c == '0);
    end
  end

endmodule

// File: rtl/rara_tx.sv
// RARA pattern transmitter: emits N "RARA" frames on a valid/ready character stream.
// Build option RARA_TX_OVERLAP_EN: successive frames share the trailing "RA" (no gap char).
module rara_tx
  import rara_tx_pkg::*;
#(
  parameter int unsigned       CNT_W     = 4,
  parameter logic [CHAR_W-1:0] IDLE_CHAR = 7'h20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  count,
  output logic [CHAR_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy,
  output logic              done
);

  tx_state_e state;
  logic      load_c;
  logic      dec_c;
  logic      xfer_c;
  logic      last;
  logic      zero;

  assign xfer_c = dout_valid && dout_ready;
  assign load_c = (state == TX_IDLE) && start && (count != '0);
  assign dec_c  = (state == TX_TA2) && xfer_c && !last && !zero;

  rara_tx_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (load_c),
    .dec      (dec_c),
    .load_val (count),
    .last     (last),
    .zero     (zero)
  );

  // Every non-idle state advances only on a transfer, so a stall holds dout and state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= TX_IDLE;
      dout       <= IDLE_CHAR;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        TX_IDLE: begin
          if (load_c) begin
            state      <= TX_TR1;
            dout       <= ASCII_R;
            dout_valid <= 1'b1;
            busy       <= 1'b1;
          end
        end
        TX_TR1: begin
          if (xfer_c) begin
            state <= TX_TA1;
            dout  <= ASCII_A;
          end
        end
        TX_TA1: begin
          if (xfer_c) begin
            state <= TX_TR2;
            dout  <= ASCII_R;
          end
        end
        TX_TR2: begin
          if (xfer_c) begin
            state <= TX_TA2;
            dout  <= ASCII_A;
          end
        end
        TX_TA2: begin
          if (xfer_c) begin
            if (last) begin
              state      <= TX_IDLE;
              dout       <= IDLE_CHAR;
              dout_valid <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
            end else begin
`ifdef RARA_TX_OVERLAP_EN
              state <= TX_TR2;
              dout  <= ASCII_R;
`else
              state <= TX_GAP;
              dout  <= IDLE_CHAR;
`endif
            end
          end
        end
        TX_GAP: begin
          if (xfer_c) begin
            state <= TX_TR1;
            dout  <= ASCII_R;
          end
        end
        default: begin
          state      <= TX_IDLE;
          dout       <= IDLE_CHAR;
          dout_valid <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rara_tx.sv
// Randomized bench for rara_tx: expected character stream is built from the frame rules.
module tb_rara_tx;

  localparam int unsigned CNT_W     = 4;
  localparam logic [6:0]  IDLE_CHAR = 7'h20;
  localparam logic [6:0]  CH_R      = 7'h52;
  localparam logic [6:0]  CH_A      = 7'h41;
  localparam int          BUDGET    = 2000;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] count;
  logic [6:0]       dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             busy;
  logic             done;

  int n_cmp = 0;
  int n_bad = 0;

  rara_tx #(
    .CNT_W     (CNT_W),
    .IDLE_CHAR (IDLE_CHAR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .count      (count),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference stream: N frames of "RARA", separated by one idle char or sharing "RA" when overlapped.
  task automatic build_stream(input int n, output logic [6:0] q[$]);
    q = {};
`ifdef RARA_TX_OVERLAP_EN
    q.push_back(CH_R);
    q.push_back(CH_A);
    for (int f = 0; f < n; f++) begin
      q.push_back(CH_R);
      q.push_back(CH_A);
    end
`else
    for (int f = 0; f < n; f++) begin
      if (f > 0) q.push_back(IDLE_CHAR);
      q.push_back(CH_R);
      q.push_back(CH_A);
      q.push_back(CH_R);
      q.push_back(CH_A);
    end
`endif
  endtask

  function automatic logic pick_ready(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // mode 0: always ready, 1: ready pattern 1,0,0,1..., 2: random ready.
  task automatic run_frames(input int n, input int mode, input bit repulse);
    logic [6:0] exp_q[$];
    int         got_n;
    int         cyc;
    bit         fin;
    bit         prev_stall;
    bit         prev_last;
    logic [6:0] prev_dout;
    logic       rdy;

    build_stream(n, exp_q);
    got_n      = 0;
    cyc        = 0;
    fin        = 1'b0;
    prev_stall = 1'b0;
    prev_last  = 1'b0;
    prev_dout  = '0;

    @(negedge clk);
    start      = 1'b1;
    count      = CNT_W'(n);
    dout_ready = pick_ready(mode, 0);
    @(negedge clk);
    start = 1'b0;
    count = CNT_W'($urandom);

    if (n == 0) begin
      for (int i = 0; i < 4; i++) begin
        check_eq("zero_busy", 32'(busy), 32'd0);
        check_eq("zero_valid", 32'(dout_valid), 32'd0);
        check_eq("zero_done", 32'(done), 32'd0);
        dout_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      return;
    end

    check_eq("first_valid", 32'(dout_valid), 32'd1);
    check_eq("first_char", 32'(dout), 32'(CH_R));

    while (!fin && cyc < BUDGET) begin
      if (prev_last) begin
        check_eq("done_pulse", 32'(done), 32'd1);
        check_eq("busy_fall", 32'(busy), 32'd0);
        check_eq("valid_fall", 32'(dout_valid), 32'd0);
        check_eq("idle_char", 32'(dout), 32'(IDLE_CHAR));
        fin = 1'b1;
      end else begin
        check_eq("early_done", 32'(done), 32'd0);
        check_eq("busy_active", 32'(busy), 32'd1);
        check_eq("valid_active", 32'(dout_valid), 32'd1);
        if (prev_stall)
          check_eq("stall_hold", 32'(dout), 32'(prev_dout));
        rdy        = pick_ready(mode, cyc + 1);
        dout_ready = rdy;
        if (repulse && got_n == 3) begin
          start = 1'b1;
          count = CNT_W'(5);
        end else begin
          start = 1'b0;
        end
        if (dout_valid && rdy) begin
          check_eq("char", 32'(dout), 32'(exp_q[got_n]));
          got_n++;
          if (got_n == exp_q.size()) prev_last = 1'b1;
        end
        prev_stall = dout_valid && !rdy;
        prev_dout  = dout;
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    if (!fin) check_eq("timeout", 32'd0, 32'd1);

    dout_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    check_eq("done_one_cycle", 32'(done), 32'd0);
    check_eq("stay_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    count      = '0;
    dout_ready = 1'b0;
    #1;
    check_eq("rst_dout", 32'(dout), 32'(IDLE_CHAR));
    check_eq("rst_valid", 32'(dout_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    run_frames(1, 0, 1'b0);
    run_frames(3, 0, 1'b0);
    run_frames(2, 1, 1'b0);
    run_frames(0, 0, 1'b0);
    run_frames(2, 0, 1'b1);
    run_frames(15, 0, 1'b0);
    for (int i = 0; i < 6; i++)
      run_frames(int'($urandom_range(1, 15)), 2, 1'($urandom_range(0, 1)));

    // Asynchronous reset during TA1 abandons the frame without a done pulse.
    @(negedge clk);
    start      = 1'b1;
    count      = CNT_W'(2);
    dout_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check_eq("pre_rst_a", 32'(dout), 32'(CH_A));
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_dout", 32'(dout), 32'(IDLE_CHAR));
    check_eq("async_valid", 32'(dout_valid), 32'd0);
    check_eq("async_busy", 32'(busy), 32'd0);
    check_eq("async_done", 32'(done), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check_eq("rst_hold_done", 32'(done), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_idle", 32'(dout_valid), 32'd0);
    check_eq("post_rst_done", 32'(done), 32'd0);
    run_frames(1, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
